coin_sequencer: RTL and testbench

Front-end controller for the `vending_machine` FSM. It accepts coin-detector pulses from three physical slots, which may arrive in the same cycle. It buffers them per denomination and replays them to the vending machine as clean, mutually exclusive one-cycle tokens. Every token is followed by an idle cycle, and issuing is paused for a programmable hold window after each dispense. It sits between the coin-slot sensors and the `one`/`two`/`five` inputs of `vending_machine`.

---
 rtl/coin_sequencer.sv | 166 ++++++++++++++++
 tb/tb_coin_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_sequencer.sv
// rtl/coin_sequencer.sv - buffers coin pulses and replays them as spaced, exclusive tokens
// Defining COIN_SEQ_STATS_EN adds the saturating tokens_issued output.
module coin_sequencer #(
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_one,
  input  logic        coin_two,
  input  logic        coin_five,
  input  logic        vm_d,
  output logic        one,
  output logic        two,
  output logic        five,
  output logic [2:0]  reject,
  output logic        busy
`ifdef COIN_SEQ_STATS_EN
  ,
  output logic [15:0] tokens_issued
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};
  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES);

  // Index 0 = one, 1 = two, 2 = five throughout.
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt      [3];
  logic [CNT_W-1:0] cnt_next [3];
  logic [2:0]       coin;
  logic [2:0]       token;
  logic [2:0]       token_next;
  logic [2:0]       drop;
  logic [2:0]       pending;
  logic [3:0]       hold_cnt;
  logic             hold_zero;
  logic             any_pending;
  logic             busy_next;

  assign coin             = {coin_five, coin_two, coin_one};
  assign {five, two, one} = token;
  assign hold_zero        = (hold_cnt == 4'd0);
  assign any_pending      = |pending;

  // The token register is high only in ISSUE, so it doubles as the decrement strobe.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_next[i] = cnt[i];
      drop[i]     = 1'b0;
      pending[i]  = (cnt[i] != '0);
      if (coin[i] && !token[i]) begin
        if (cnt[i] == CNT_FULL) begin
          drop[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end else if (!coin[i] && token[i]) begin
        cnt_next[i] = cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE also waits out a vm_d seen this cycle so no token lands inside the hold window.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_pending && hold_zero && !vm_d) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = GAP;
      end
      GAP: begin
        if (!hold_zero || vm_d) begin
          state_next = HOLD;
        end else if (any_pending) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (hold_zero) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Selection uses the counters of the cycle before ISSUE so the token can be registered.
  always_comb begin
    token_next = 3'b000;
    if (state_next == ISSUE) begin
      if (pending[2]) begin
        token_next = 3'b100;
      end else if (pending[1]) begin
        token_next = 3'b010;
      end else begin
        token_next = 3'b001;
      end
    end
    busy_next = (state_next != IDLE);
    for (int i = 0; i < 3; i++) begin
      if (cnt_next[i] != '0) begin
        busy_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      hold_cnt <= 4'd0;
      token    <= 3'b000;
      reject   <= 3'b000;
      busy     <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (vm_d) begin
        hold_cnt <= HOLD_LOAD;
      end else if (!hold_zero) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      token  <= token_next;
      reject <= drop;
      busy   <= busy_next;
    end
  end

`ifdef COIN_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tokens_issued <= 16'd0;
    end else if (state == ISSUE && tokens_issued != 16'hFFFF) begin
      tokens_issued <= tokens_issued + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_sequencer.sv
// tb/tb_coin_sequencer.sv - scoreboard bench for coin_sequencer with directed and random phases
module tb_coin_sequencer;
  localparam int H   = 4;
  localparam int CAP = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_one = 1'b0;
  logic       coin_two = 1'b0;
  logic       coin_five = 1'b0;
  logic       vm_d = 1'b0;
  logic       one;
  logic       two;
  logic       five;
  logic [2:0] reject;
  logic       busy;
`ifdef COIN_SEQ_STATS_EN
  logic [15:0] tokens_issued;
`endif

  coin_sequencer #(.CNT_W(3), .HOLD_CYCLES(H)) dut (
    .clk(clk),
    .reset(reset),
    .coin_one(coin_one),
    .coin_two(coin_two),
    .coin_five(coin_five),
    .vm_d(vm_d),
    .one(one),
    .two(two),
    .five(five),
    .reject(reject),
    .busy(busy)
`ifdef COIN_SEQ_STATS_EN
    ,
    .tokens_issued(tokens_issued)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  exp_t tok_q[$];
  exp_t rej_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_vm = -1000;
  int   last_tok = -1000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) last_vm <= -1000;
    else if (vm_d) last_vm <= cyc;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_tok(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    tok_q.push_back(e);
  endfunction

  function automatic void push_rej(input int mask, input int at);
    exp_t e;
    e.kind = mask;
    e.at   = at;
    rej_q.push_back(e);
  endfunction

  // Monitor: pops expectations whenever a token or reject appears.
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if ({five, two, one} != 3'b000) begin
      kind = five ? 2 : (two ? 1 : 0);
      check("token_onehot", $countones({five, two, one}), 1);
      check("token_spacing", int'(cyc - last_tok >= 2), 1);
      check("hold_window", int'(cyc >= last_vm + H + 2), 1);
      if (tok_q.size() == 0) begin
        check("unexpected_token", kind, -1);
      end else begin
        e = tok_q.pop_front();
        check("token_kind", kind, e.kind);
        if (e.at >= 0) check("token_cycle", cyc, e.at);
      end
      last_tok = cyc;
    end
    if (reject != 3'b000) begin
      if (rej_q.size() == 0) begin
        check("unexpected_reject", int'(reject), 0);
      end else begin
        e = rej_q.pop_front();
        check("reject_bits", int'(reject), e.kind);
        check("reject_cycle", cyc, e.at);
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic v);
    @(negedge clk);
    {coin_five, coin_two, coin_one} = c;
    vm_d = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    drive(3'b000, 1'b0);
    while ((tok_q.size() != 0 || rej_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, tok_q.size() + rej_q.size() + int'(busy), 0);
    tok_q.delete();
    rej_q.delete();
    idle(H + 4);
  endtask

  // Coins arrive while vm_d is held high, so nothing issues until it drops; then
  // tokens follow strictly by denomination every second cycle.
  // mode: 0 coin_one only, 1 random mix, 2 coin_two only.
  // action: 0 none, 1 coin_two during the first ISSUE, 2 reset during the first ISSUE.
  task automatic burst(input int len, input int mode, input int action, input string name);
    int         pend[3];
    int         tv;
    int         s;
    int         mask;
    logic [2:0] c;
    pend = '{0, 0, 0};
    tv = cyc;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       c = 3'b001;
        1:       c = 3'($urandom_range(0, 7));
        default: c = 3'b010;
      endcase
      drive(c, 1'b1);
      mask = 0;
      for (int d = 0; d < 3; d++) begin
        if (c[d]) begin
          if (pend[d] < CAP) pend[d]++;
          else mask |= (1 << d);
        end
      end
      if (mask != 0) push_rej(mask, cyc + 1);
      tv = cyc;
    end
    drive(3'b000, 1'b0);
    s = tv + H + 2;
    if (action == 1) pend[1]++;
    if (action == 2) begin
      for (int d = 2; d >= 0; d--) begin
        if (pend[d] > 0) begin
          push_tok(d, s);
          break;
        end
      end
    end else begin
      for (int d = 2; d >= 0; d--) begin
        for (int k = 0; k < pend[d]; k++) begin
          push_tok(d, s);
          s += 2;
        end
      end
    end
    if (action != 0) begin
      while (cyc < tv + H + 2) @(negedge clk);
      if (action == 1) begin
        coin_two = 1'b1;
        @(negedge clk);
        coin_two = 1'b0;
      end else begin
        reset = 1'b0;
        @(negedge clk);
        check("mid_issue_reset_outputs", int'({one, two, five, reject, busy}), 0);
`ifdef COIN_SEQ_STATS_EN
        check("mid_issue_reset_stats", int'(tokens_issued), 0);
`endif
        reset = 1'b1;
      end
    end
    wait_drain(name);
  endtask

  // Single denomination, at most CAP coins, vm_d pulses at random while draining.
  task automatic drain_phase();
    int         kind;
    int         n;
    int         sent;
    int         guard;
    logic [2:0] c;
    logic       v;
    kind  = $urandom_range(0, 2);
    n     = $urandom_range(1, CAP);
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 100) begin
      c = 3'b000;
      if ($urandom_range(0, 2) == 0) begin
        c[kind] = 1'b1;
        sent++;
        push_tok(kind, -1);
      end
      v = ($urandom_range(0, 9) == 0);
      drive(c, v);
      guard++;
    end
    wait_drain("drain_phase_done");
  endtask

  initial begin
    int t0;

    drive(3'b111, 1'b0);
    check("reset_outputs", int'({one, two, five, reject, busy}), 0);
    drive(3'b111, 1'b0);
    check("reset_outputs", int'({one, two, five, reject, busy}), 0);
    drive(3'b000, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(3'b000, 1'b0);
      check("post_reset_idle", int'({one, two, five, reject, busy}), 0);
    end

    drive(3'b111, 1'b0);
    t0 = cyc;
    push_tok(2, t0 + 2);
    push_tok(1, t0 + 4);
    push_tok(0, t0 + 6);
    drive(3'b000, 1'b0);
    while (cyc < t0 + 7) @(negedge clk);
    check("busy_before_fall", int'(busy), 1);
    @(negedge clk);
    check("busy_fall", int'(busy), 0);
    wait_drain("simultaneous_drain");

    burst(9, 0, 0, "overflow_drain");

    drive(3'b100, 1'b0);
    t0 = cyc;
    push_tok(2, t0 + 2);
    push_tok(2, -1);
    drive(3'b100, 1'b0);
    drive(3'b000, 1'b0);
    drive(3'b000, 1'b1);
    wait_drain("dispense_hold_drain");

    burst(7, 2, 1, "full_incdec_drain");
    burst(3, 0, 2, "mid_issue_reset_drain");

    for (int r = 0; r < 12; r++) burst($urandom_range(3, 16), 1, 0, "random_burst_drain");
    for (int r = 0; r < 12; r++) drain_phase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
